// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : arb_pkg
// Brief  : Shared defaults, FSM state encoding and source index type for the
//          round-robin bus arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
package arb_pkg;

  localparam int c_n_req_default  = 4;
  localparam int c_data_w_default = 8;
  localparam int c_src_w_max      = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Wide enough for the largest supported requester count (8).
  typedef logic [c_src_w_max-1:0] src_t;

endpackage
`default_nettype wire

// File: rtl/bus_rr_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module : rr_picker
// Brief  : Combinational round-robin selector; first set request bit at or
//          after last_grant+1, wrapping.
// Rev    : 1.0 - initial release
// ============================================================================
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int SRC_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SRC_W-1:0] last_grant,
  output logic             any,
  output logic [SRC_W-1:0] winner
);

  logic w_found;

  // Offset i walks from last_grant+1 round to last_grant itself.
  always_comb begin
    any     = |req;
    winner  = '0;
    w_found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!w_found && req[j] && (j == ((int'(last_grant) + i) % N_REQ))) begin
          winner  = SRC_W'(j);
          w_found = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : bus_rr_arbiter
// Brief  : N-way round-robin arbiter onto a registered shared bus with a
//          saturating accepted-transfer counter.
// Rev    : 1.0 - initial release
// ============================================================================
module bus_rr_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ  = c_n_req_default,
  parameter int DATA_W = c_data_w_default,
  parameter int SRC_W  = $clog2(N_REQ)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [N_REQ-1:0]             i_req_valid,
  input  logic [N_REQ-1:0][DATA_W-1:0] i_req_data,
  output logic [N_REQ-1:0]             o_req_ready,
  output logic                         o_valid,
  output logic [DATA_W-1:0]            o_data,
  output logic [SRC_W-1:0]             o_src,
  input  logic                         i_ready,
  output logic [15:0]                  o_grant_cnt
);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_valid;
  logic [DATA_W-1:0]   r_data;
  logic [SRC_W-1:0]    r_src;
  logic [SRC_W-1:0]    r_last_grant;
  logic [15:0]         r_cnt;

  logic                w_any;
  logic [SRC_W-1:0]    w_winner;
  logic                w_can_load;
  logic                w_load;
  logic [N_REQ-1:0]    w_ready;

  rr_picker #(
    .N_REQ (N_REQ),
    .SRC_W (SRC_W)
  ) u_picker (
    .req        (i_req_valid),
    .last_grant (r_last_grant),
    .any        (w_any),
    .winner     (w_winner)
  );

  assign w_can_load = (r_state == IDLE) || i_ready;

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_ready      = '0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_load       = 1'b1;
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (i_ready) begin
          if (w_any) begin
            w_load = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
    // Ready follows the picker only, never the winner's own valid directly.
    if (w_load && w_can_load && !i_rst) begin
      w_ready[w_winner] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_src        <= '0;
      r_last_grant <= SRC_W'(N_REQ - 1);
      r_cnt        <= 16'd0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_valid      <= 1'b1;
        r_data       <= i_req_data[w_winner];
        r_src        <= w_winner;
        r_last_grant <= w_winner;
      end else if ((r_state == HOLD) && i_ready) begin
        r_valid <= 1'b0;
      end
      if (r_valid && i_ready && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign o_req_ready = w_ready;
  assign o_valid     = r_valid;
  assign o_data      = r_data;
  assign o_src       = r_src;
  assign o_grant_cnt = r_cnt;

endmodule
`default_nettype wire

// File: doc/bus_rr_arbiter.md
BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the shared data bus width.
REQ-003 The block SHALL have port i_clk  input  1  meaning the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port i_rst  input  1  meaning reset, synchronous and active-high.
REQ-005 The block SHALL have port i_req_valid  input  N_REQ  meaning per-requester data-valid.
REQ-006 The block SHALL have port i_req_data  input  N_REQ x DATA_W  meaning per-requester data, packed array indexed by requester.
REQ-007 The block SHALL have port o_req_ready  output  N_REQ  meaning per-requester accept, one-hot or zero.
REQ-008 The block SHALL have port o_valid  output  1  meaning the shared bus holds valid data.
REQ-009 The block SHALL have port o_data  output  DATA_W  meaning the shared bus data, registered.
REQ-010 The block SHALL have port o_src  output  clog2(N_REQ)  meaning the index of the requester that owns o_data.
REQ-011 The block SHALL have port i_ready  input  1  meaning the downstream accepts o_data this cycle.
REQ-012 The block SHALL have port o_grant_cnt  output  16  meaning the total accepted transfers, saturating.

Function
REQ-013 The FSM SHALL have states IDLE (output register empty) and HOLD (output register full).
REQ-014 The output register SHALL be able to load when state==IDLE, or when state==HOLD and i_ready==1.
REQ-015 When the register can load and any i_req_valid is set, the block SHALL select winner w round-robin: the first set bit searching upward from last_grant+1, wrapping modulo N_REQ.
REQ-016 In that cycle o_req_ready[w] SHALL be 1 combinationally and all other o_req_ready bits 0; a requester transfers on valid&&ready.
REQ-017 On the next edge the block SHALL set o_data=i_req_data[w], o_src=w, o_valid=1 and last_grant=w, and SHALL move to or stay in HOLD, giving one cycle latency.
REQ-018 In HOLD with i_ready==1 and no i_req_valid set, the block SHALL go to IDLE and clear o_valid on the next edge.
REQ-019 In HOLD with i_ready==0, o_valid, o_data and o_src SHALL hold stable and o_req_ready SHALL be all zero.
REQ-020 Back-to-back transfers SHALL sustain one transfer per cycle while i_ready==1 and requests are pending.
REQ-021 o_req_ready SHALL never depend on i_req_valid of the selected requester except through selection, so that no combinational loop exists from valid to ready within the same requester.
REQ-022 o_grant_cnt SHALL increment on each o_valid&&i_ready and SHALL saturate at 16'hFFFF.
REQ-023 i_req_valid bits that drop before being granted SHALL be ignored with no state change.

Reset
REQ-024 While i_rst==1 at an edge, the block SHALL set state=IDLE, o_valid=0, o_data=0, o_src=0, o_grant_cnt=0 and last_grant=N_REQ-1, so that requester 0 has first priority.
REQ-025 While i_rst==1, o_req_ready SHALL be forced to 0.
REQ-026 A reset asserted in HOLD SHALL discard the held word with no transfer counted.

Structure
REQ-027 Package arb_pkg SHALL hold the default N_REQ and DATA_W, the state enum (IDLE, HOLD), and the src index typedef.
REQ-028 Round-robin selection SHALL be a separate combinational sub-module, rr_picker (inputs req and last_grant; outputs any and winner).
REQ-029 The top SHALL instantiate rr_picker once, with one always_ff block for the FSM, output register and counter.

Verification
REQ-030 After reset, valid=4'b0001 and data0=8'hFF -> ready0 in the same cycle, then o_valid=1, o_data=8'hFF, o_src=0 on the next edge.
REQ-031 valid=4'b1111 with i_ready held at 1 for 8 cycles -> o_src sequence 0,1,2,3,0,1,2,3 and o_grant_cnt=8.
REQ-032 o_valid=1 and i_ready=0 for 5 cycles while valid=4'b0110 -> o_data and o_src stable and o_req_ready=0; on i_ready=1, the next winner follows last_grant.
REQ-033 Reset pulsed while in HOLD with o_data=8'hA5 -> o_valid=0, o_grant_cnt=0, and the next grant with valid=4'b1111 goes to src 0.
REQ-034 o_grant_cnt preloaded near 16'hFFFE, followed by 3 accepted transfers -> the counter reads 16'hFFFF.
REQ-035 last_grant=3 and valid=4'b1000 only -> src 3 is granted again (wrap search returns to self).
